// File: rtl/prng_pkg.sv
// prng_pkg: shared defaults and state encoding for the LFSR PRNG
package prng_pkg;
  localparam int PRNG_W = 8;
  localparam logic [7:0] PRNG_TAPS = 8'hB8;
  localparam logic [7:0] PRNG_SEED = 8'hDA;
  typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational Fibonacci LFSR advance, STEPS shifts unrolled
module lfsr_step #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] i_s,
  output logic [WIDTH-1:0] o_s
);
  always_comb begin
    o_s = i_s;
    for (int k = 0; k < STEPS; k++) o_s = {o_s[WIDTH-2:0], ^(o_s & TAPS)};
  end
endmodule

// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: LFSR random source with valid/ready output, seed load and wrap detect
// Define PRNG_ZERO_GUARD_EN to replace a zero seed with SEED_DEFAULT and pulse o_lockup.
module lfsr_prng_gen
  import prng_pkg::*;
#(
  parameter int WIDTH = PRNG_W,
  parameter logic [WIDTH-1:0] TAPS = PRNG_TAPS,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = PRNG_SEED,
  parameter int STEPS = 1,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_prng,
  output logic             o_wrap,
  output logic             o_lockup
);
  state_e r_state, w_next;
  logic [WIDTH-1:0] r_lfsr, r_seed, w_adv, w_seed;
  logic [OUT_W-1:0] r_out;
  logic r_wrap, r_lockup, w_load, w_zero;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS)) u_step (.i_s(r_lfsr), .o_s(w_adv));

`ifdef PRNG_ZERO_GUARD_EN
  assign w_zero = i_seed == '0;
  assign w_seed = w_zero ? SEED_DEFAULT : i_seed;
`else
  assign w_zero = 1'b0;
  assign w_seed = i_seed;
`endif

  // A stalled FULL word holds; otherwise the next word is fetched whenever enabled.
  always_comb begin
    w_load = !i_seed_load && i_en && (r_state == EMPTY || i_ready);
    w_next = i_seed_load ? EMPTY : (r_state == FULL && !i_ready) ? FULL : i_en ? FULL : EMPTY;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= EMPTY;
    else r_state <= w_next;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_lfsr   <= SEED_DEFAULT;
      r_seed   <= SEED_DEFAULT;
      r_out    <= '0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap   <= w_load && w_adv == r_seed;
      r_lockup <= i_seed_load && w_zero;
      if (i_seed_load) begin
        r_lfsr <= w_seed;
        r_seed <= w_seed;
      end else if (w_load) begin
        r_out  <= r_lfsr[OUT_W-1:0];
        r_lfsr <= w_adv;
      end
    end

  assign o_valid  = r_state == FULL;
  assign o_prng   = r_out;
  assign o_wrap   = r_wrap;
  assign o_lockup = r_lockup;
endmodule

// File: tb/tb_lfsr_prng_gen.sv
// tb_lfsr_prng_gen: scoreboard bench for lfsr_prng_gen with directed and random phases
module tb_lfsr_prng_gen;
  logic clk = 0, reset = 1, i_en = 0, i_seed_load = 0, i_ready = 0;
  logic [7:0] i_seed = 0, o_prng;
  logic o_valid, o_wrap, o_lockup;
  int errors = 0, checks = 0, wrap_cnt = 0;
  logic [7:0] exp_q[$];
  logic prev_hold = 0, prev_zload = 0;
  logic [7:0] prev_prng = 0;
`ifdef PRNG_ZERO_GUARD_EN
  localparam bit GUARD = 1;
`else
  localparam bit GUARD = 0;
`endif

  always #5 clk = ~clk;

  lfsr_prng_gen dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_seed_load(i_seed_load), .i_seed(i_seed),
    .o_valid(o_valid), .i_ready(i_ready), .o_prng(o_prng), .o_wrap(o_wrap), .o_lockup(o_lockup)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] nxt(logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic logic [7:0] eff_seed(logic [7:0] s);
    return (GUARD && s == 0) ? 8'hDA : s;
  endfunction

  task automatic restart(logic [7:0] s);
    exp_q.delete();
    for (int k = 0; k < 600; k++) begin
      exp_q.push_back(s);
      s = nxt(s);
    end
  endtask

  task automatic cyc(logic en, logic rdy, logic ld = 0, logic [7:0] sd = 0);
    i_en = en; i_ready = rdy; i_seed_load = ld; i_seed = sd;
    if (ld) restart(eff_seed(sd));
    @(posedge clk); #2;
    i_seed_load = 0;
  endtask

  task automatic do_reset();
    reset = 1; i_en = 0; i_ready = 0; i_seed_load = 0;
    restart(8'hDA);
    repeat (2) @(posedge clk);
    #2 reset = 0;
  endtask

  // Monitor: pops one expected word per transfer and checks hold/lockup behaviour.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 0;
      prev_zload = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_prng", o_prng, prev_prng);
      end
      chk("lockup", o_lockup, GUARD ? prev_zload : 1'b0);
      if (o_wrap) wrap_cnt++;
      if (!i_seed_load && o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("underflow", 1, 0);
        else chk("word", o_prng, exp_q.pop_front());
      end
      prev_hold = o_valid && !i_ready && !i_seed_load;
      prev_prng = o_prng;
      prev_zload = i_seed_load && i_seed == 0;
    end
  end

  initial begin
    restart(8'hDA);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_prng", o_prng, 0);
    chk("rst_wrap", o_wrap, 0);
    chk("rst_lockup", o_lockup, 0);
    cyc(1, 1);
    chk("latency_valid", o_valid, 1);
    chk("first_word", o_prng, 8'hDA);
    cyc(1, 1);
    chk("second_word", o_prng, 8'hB5);
    repeat (5) cyc(1, 0);
    chk("bp_hold", o_prng, 8'hB5);
    cyc(1, 1);
    chk("bp_next", o_prng, 8'h6B);
    cyc(1, 1, 1, 8'h01);
    chk("seed_flush", o_valid, 0);
    cyc(1, 1);
    chk("seed_word0", o_prng, 8'h01);
    cyc(1, 1);
    chk("seed_word1", o_prng, 8'h02);
    cyc(1, 1, 1, 8'h00);
    chk("zero_lockup", o_lockup, GUARD);
    cyc(1, 1);
    chk("zero_word0", o_prng, GUARD ? 8'hDA : 8'h00);
    cyc(1, 1);
    chk("zero_word1", o_prng, GUARD ? 8'hB5 : 8'h00);
    cyc(1, 1, 1, 8'h5C);
    cyc(1, 1);
    cyc(1, 1);
    chk("pre_reset_valid", o_valid, 1);
    reset = 1;
    #1 chk("async_reset_valid", o_valid, 0);
    do_reset();
    wrap_cnt = 0;
    repeat (256) cyc(1, 1);
    chk("wrap_word", o_prng, 8'hDA);
    repeat (44) cyc(1, 1);
    chk("wrap_count", wrap_cnt, 1);
    do_reset();
    for (int n = 0; n < 500; n++)
      cyc($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 40 == 0,
          ($urandom % 4 == 0) ? 8'h00 : 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
